// File: rtl/regfile_mp_sb_pkg.sv
// Shared sizing defaults for the multi-port register file and its scoreboard.
package regfile_mp_sb_pkg;
    localparam int REG_SIZE = 32;
    localparam int REG_N    = 32;
    localparam int REG_ADDR = 5;
    localparam int RF_NRD   = 2;
    localparam int RF_NWR   = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register with flush > alloc > write priority.
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREGS  = REG_N,
    parameter int ADDR_W = REG_ADDR,
    parameter int NRD    = RF_NRD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc,
    input  logic [ADDR_W-1:0]     alloc_reg,
    input  logic                  flush,
    input  logic [NREGS-1:0]      wr_hit,
    input  logic [NRD*ADDR_W-1:0] rreg,
    output logic [NRD-1:0]        busy_out
);
    logic [NREGS-1:0] busy;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy <= '0;
        end else begin
            // Register 0 never matches, so busy[0] stays clear forever.
            for (int r = 1; r < NREGS; r++) begin
                if (alloc && alloc_reg == ADDR_W'(r))
                    busy[r] <= 1'b1;
                else if (wr_hit[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_out = '0;
        for (int k = 0; k < NRD; k++) begin
            if (int'(rreg[k*ADDR_W +: ADDR_W]) < NREGS)
                busy_out[k] = busy[rreg[k*ADDR_W +: ADDR_W]];
        end
    end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass and integrated busy scoreboard.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = REG_SIZE,
    parameter int NREGS  = REG_N,
    parameter int ADDR_W = REG_ADDR,
    parameter int NRD    = RF_NRD,
    parameter int NWR    = RF_NWR,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rreg,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*ADDR_W-1:0] wreg,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic                  alloc,
    input  logic [ADDR_W-1:0]     alloc_reg,
    input  logic                  flush
);
    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [NREGS];
    logic [NRD-1:0]    busy_raw;

    // Ascending port scan so the highest-index port wins a conflict.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (!reset && r != 0 && wen[j] && wreg[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (wr_hit[r]) mem[r] <= wr_val[r];
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .alloc     (alloc),
        .alloc_reg (alloc_reg),
        .flush     (flush),
        .wr_hit    (wr_hit),
        .rreg      (rreg),
        .busy_out  (busy_raw)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              valid;
        logic              hit;
        logic [DATA_W-1:0] byp;

        assign idx   = rreg[k*ADDR_W +: ADDR_W];
        assign valid = (idx != '0) && (int'(idx) < NREGS);

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NWR; j++) begin
                if (BYPASS != 0 && !reset && valid && wen[j] && wreg[j*ADDR_W +: ADDR_W] == idx) begin
                    hit = 1'b1;
                    byp = wdata[j*DATA_W +: DATA_W];
                end
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = !valid ? '0 : (hit ? byp : mem[idx]);
        assign rbusy[k] = valid && busy_raw[k] && !hit;
    end
endmodule
